inst_encoder: RTL and testbench
===============================

# inst_encoder

Sequential RV32I instruction encoder: the inverse of the pipeline's instruction decoder. Accepts decoded instruction fields (opcode, funct3, funct7, rs1, rs2, rd, immediate) over a valid/ready handshake and packs them into 32-bit instruction words. Emits each word with a sequential instruction-memory address and a range-error flag through a 2-entry output FIFO. Sits between the test/program-generation front end and the instruction-memory writer.

## Interface
- BASE_ADDR, 32'h0000_0000, address tagged on the first word after reset; must be a multiple of 4.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- in_valid_i  in  1  field tuple valid.
- in_ready_o  out  1  encoder can accept a tuple this cycle.
- opcode_i  in  7  instruction opcode.
- funct3_i  in  3  funct3 field.
- funct7_i  in  7  funct7 field; used for R-type and for shift-immediates (opcode 0010011, funct3 001/101).
- rs1_i, rs2_i, rd_i  in  5 each  register indices.
- imm_i  in  32  full sign-extended immediate value, byte offset for B/J, unshifted upper value for U (low 12 bits zero).
- out_valid_o  out  1  FIFO head valid.
- out_ready_i  in  1  consumer accepts the head word.
- inst_o  out  32  encoded instruction.
- addr_o  out  32  address of inst_o.
- err_o  out  1  head word had an opcode or immediate-range error.

## Operation
- Format from opcode:
  - 0110011 → R.
  - 1100111, 0000011, 0010011 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 0010111, 0110111 → U.
  - 1101111 → J.
  - Anything else → invalid.
- Encoding, shown as {inst[31] … inst[0]}:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - I shift (0010011 with funct3 001/101): {funct7, imm[4:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
  - Invalid opcode: word is 32'h0000_0013 (NOP).
- Fields unused by a format are ignored.
- err set when:
  - Invalid opcode.
  - I/S: imm_i[31:11] not all-equal.
  - Shift: imm_i[31:5] ≠ 0.
  - B: imm_i[31:12] not all-equal, or imm_i[0]=1.
  - J: imm_i[31:20] not all-equal, or imm_i[0]=1.
  - U: imm_i[11:0] ≠ 0.
- On err (except invalid opcode), the word is still encoded from the truncated fields above.
- Address counter:
  - Starts at BASE_ADDR.
  - Each accepted tuple is tagged with the current value; the counter then adds 4.
  - Wraps modulo 2^32 (32'hFFFF_FFFC → 0).
- FIFO: 2 entries of {inst, addr, err}, plus a 2-bit occupancy count 0..2.
  - Push on in_valid_i & in_ready_o.
  - Pop on out_valid_o & out_ready_i.
  - Simultaneous push and pop: count unchanged, order preserved.
- in_ready_o = (count < 2), derived from registered state only; no combinational path from out_ready_i.
- out_valid_o = (count > 0).
- inst_o/addr_o/err_o show the head entry while out_valid_o=1 and are driven to 0 while out_valid_o=0.

## Timing
- Reset (asynchronous, immediate): count=0, address counter=BASE_ADDR. Outputs: out_valid_o=0, inst_o=0, addr_o=0, err_o=0, in_ready_o=1.
- Reset asserted mid-operation discards all FIFO contents; a pending handshake in that cycle is lost.
- Latency:
  - A tuple accepted at edge N into an empty FIFO is presented with out_valid_o=1 in the cycle after edge N (one cycle).
  - No combinational input-to-output path.
- Throughput: one word per cycle while out_ready_i=1.
- Full (count=2): in_ready_o=0; no push even if out_ready_i=1 that cycle. Ready returns the cycle after a pop.
- Empty with out_ready_i=1: no pop, no state change.
- in_valid_i with in_ready_o=0: no effect, and the address counter does not advance.

## Test plan
- Reset, then push addi (opcode 0010011, f3 000, rd 1, rs1 0, imm 5) with out_ready_i=1 → next cycle inst_o=32'h0050_0093, addr_o=BASE_ADDR, err_o=0.
- Push sub (0110011, f7 0100000, rd 3, rs1 1, rs2 2), beq (1100011, rs1 1, rs2 2, imm 32'hFFFF_FFF8), then jal (1101111, rd 1, imm 32'h800) back-to-back:
  - Outputs 32'h4020_81B3, 32'hFE20_8CE3, 32'h0010_00EF on consecutive cycles.
  - addr_o = 0, 4, 8.
- addi with imm 32'h800 → inst_o=32'h8000_0093, err_o=1. Opcode 7'b1111111 → inst_o=32'h0000_0013, err_o=1.
- Backpressure: out_ready_i=0, in_valid_i=1 for 4 cycles → exactly 2 accepted (in_ready_o low from the 3rd cycle). Raise out_ready_i → words drain in order, 3rd tuple accepted the cycle after the first pop, addr_o sequence 0, 4, 8.
- BASE_ADDR=32'hFFFF_FFF8, push 3 words → addr_o = FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert rst_i mid-stream with count=2 → out_valid_o=0 immediately; after release the next word has addr_o=BASE_ADDR.

Source files
------------

// File: rtl/inst_encoder.sv
// RV32I field-to-word encoder feeding a 2-entry output FIFO tagged with sequential addresses.
// 1-cycle latency; in_ready_o drops when the FIFO holds 2 words, independent of out_ready_i.
module inst_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [4:0]  rd_i,
    input  logic [31:0] imm_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] addr_o,
    output logic        err_o
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        err;
    } entry_t;

    entry_t [1:0] mem_q, mem_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   count_q, count_d;
    logic [31:0]  addr_q, addr_d;

    logic [31:0]  enc_inst;
    logic         enc_err;
    logic         fits12, fits13, fits21, is_shift;
    logic         push, pop;
    entry_t       head;

    // An immediate fits N signed bits when everything above bit N-1 replicates bit N-1.
    assign fits12   = (imm_i[31:11] == {21{imm_i[11]}});
    assign fits13   = (imm_i[31:12] == {20{imm_i[12]}});
    assign fits21   = (imm_i[31:20] == {12{imm_i[20]}});
    assign is_shift = (opcode_i == OP_IMM) && (funct3_i == 3'b001 || funct3_i == 3'b101);

    always_comb begin
        enc_inst = NOP;
        enc_err  = 1'b1;
        case (opcode_i)
            OP_R: begin
                enc_inst = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
                enc_err  = 1'b0;
            end
            OP_JALR, OP_LOAD, OP_IMM: begin
                if (is_shift) begin
                    enc_inst = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, opcode_i};
                    enc_err  = |imm_i[31:5];
                end else begin
                    enc_inst = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
                    enc_err  = ~fits12;
                end
            end
            OP_STORE: begin
                enc_inst = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
                enc_err  = ~fits12;
            end
            OP_BR: begin
                enc_inst = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                            imm_i[4:1], imm_i[11], opcode_i};
                enc_err  = ~fits13 | imm_i[0];
            end
            OP_AUIPC, OP_LUI: begin
                enc_inst = {imm_i[31:12], rd_i, opcode_i};
                enc_err  = |imm_i[11:0];
            end
            OP_JAL: begin
                enc_inst = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
                enc_err  = ~fits21 | imm_i[0];
            end
            default: begin
                enc_inst = NOP;
                enc_err  = 1'b1;
            end
        endcase
    end

    assign in_ready_o  = (count_q != 2'd2);
    assign out_valid_o = (count_q != 2'd0);
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        addr_d   = addr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{inst: enc_inst, addr: addr_q, err: enc_err};
            wr_ptr_d        = ~wr_ptr_q;
            addr_d          = addr_q + 32'd4;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q    <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            addr_q   <= BASE_ADDR;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
        end
    end

    assign head   = mem_q[rd_ptr_q];
    assign inst_o = out_valid_o ? head.inst : 32'd0;
    assign addr_o = out_valid_o ? head.addr : 32'd0;
    assign err_o  = out_valid_o & head.err;

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed scenarios plus randomized traffic against a queue-based model.
module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
    logic [31:0] imm = '0;

    logic        in_ready0, out_valid0, err0;
    logic [31:0] inst0, addr0;
    logic        in_ready1, out_valid1, err1;
    logic [31:0] inst1, addr1;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        err;
    } exp_t;

    always #5 clk = ~clk;

    inst_encoder dut0 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready0),
        .opcode_i(opcode), .funct3_i(funct3), .funct7_i(funct7),
        .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .imm_i(imm),
        .out_valid_o(out_valid0), .out_ready_i(out_ready),
        .inst_o(inst0), .addr_o(addr0), .err_o(err0)
    );

    inst_encoder #(.BASE_ADDR(32'hFFFF_FFF8)) dut1 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready1),
        .opcode_i(opcode), .funct3_i(funct3), .funct7_i(funct7),
        .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .imm_i(imm),
        .out_valid_o(out_valid1), .out_ready_i(out_ready),
        .inst_o(inst1), .addr_o(addr1), .err_o(err1)
    );

    // Reference: bit placement by shift/mask arithmetic, range errors by signed value bounds.
    function automatic logic [32:0] model_encode(input logic [31:0] op, f3, f7, r1, r2, d, im);
        int          sv;
        logic [31:0] w;
        logic        e;
        sv = $signed(im);
        w  = 32'h13;
        e  = 1'b1;
        case (op)
            32'h33: begin
                w = (f7 << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12) | (d << 7) | op;
                e = 1'b0;
            end
            32'h67, 32'h03, 32'h13: begin
                if (op == 32'h13 && (f3 == 32'd1 || f3 == 32'd5)) begin
                    w = (f7 << 25) | ((im & 32'h1F) << 20) | (r1 << 15) | (f3 << 12) | (d << 7) | op;
                    e = (im > 32'd31);
                end else begin
                    w = ((im & 32'hFFF) << 20) | (r1 << 15) | (f3 << 12) | (d << 7) | op;
                    e = (sv < -2048) || (sv > 2047);
                end
            end
            32'h23: begin
                w = (((im >> 5) & 32'h7F) << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12)
                    | ((im & 32'h1F) << 7) | op;
                e = (sv < -2048) || (sv > 2047);
            end
            32'h63: begin
                w = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | (r2 << 20)
                    | (r1 << 15) | (f3 << 12) | (((im >> 1) & 32'hF) << 8)
                    | (((im >> 11) & 32'h1) << 7) | op;
                e = (sv < -4096) || (sv > 4095) || ((im & 32'h1) != 0);
            end
            32'h17, 32'h37: begin
                w = (im & 32'hFFFF_F000) | (d << 7) | op;
                e = ((im & 32'hFFF) != 0);
            end
            32'h6F: begin
                w = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                    | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12) | (d << 7) | op;
                e = (sv < -1048576) || (sv > 1048575) || ((im & 32'h1) != 0);
            end
            default: begin
                w = 32'h13;
                e = 1'b1;
            end
        endcase
        return {e, w};
    endfunction

    task automatic set_in(input logic v, input logic [31:0] op, f3, f7, r1, r2, d, im);
        in_valid = v;
        opcode   = op[6:0];
        funct3   = f3[2:0];
        funct7   = f7[6:0];
        rs1      = r1[4:0];
        rs2      = r2[4:0];
        rd       = d[4:0];
        imm      = im;
    endtask

    task automatic set_addi(input logic [31:0] im);
        set_in(1'b1, 32'h13, 0, 0, 0, 0, 1, im);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid0); end
        checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready0); end
        checks++; if ({inst0, addr0, err0} !== 65'd0) begin errors++; $display("FAIL reset_outputs: inst=%h addr=%h err=%b want zeros", inst0, addr0, err0); end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin errors++; $display("FAIL post_reset_idle: valid=%b ready=%b want 0/1", out_valid0, in_ready0); end
        next_cycle();
    endtask

    task automatic test_addi();
        do_reset();
        out_ready = 1'b1;
        set_addi(32'd5);
        @(negedge clk);
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL addi_no_comb_path: valid=%b want 0", out_valid0); end
        next_cycle();
        idle();
        @(negedge clk);
        checks++; if (out_valid0 !== 1'b1 || inst0 !== 32'h0050_0093 || addr0 !== 32'd0 || err0 !== 1'b0)
        begin errors++; $display("FAIL addi_word: valid=%b inst=%h addr=%h err=%b want 1/00500093/0/0", out_valid0, inst0, addr0, err0); end
        next_cycle();
        @(negedge clk);
        checks++; if (out_valid0 !== 1'b0 || inst0 !== 32'd0) begin errors++; $display("FAIL addi_drained: valid=%b inst=%h want 0/0", out_valid0, inst0); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w [3];
        exp_w[0] = 32'h4020_81B3;
        exp_w[1] = 32'hFE20_8CE3;
        exp_w[2] = 32'h0010_00EF;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: set_in(1'b1, 32'h33, 0, 32'h20, 1, 2, 3, 0);
                1: set_in(1'b1, 32'h63, 0, 0, 1, 2, 0, 32'hFFFF_FFF8);
                2: set_in(1'b1, 32'h6F, 0, 0, 0, 0, 1, 32'h800);
                default: idle();
            endcase
            @(negedge clk);
            checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready0); end
            if (i > 0) begin
                checks++;
                if (out_valid0 !== 1'b1 || inst0 !== exp_w[i-1] || addr0 !== 32'(4 * (i - 1)) || err0 !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_word[%0d]: valid=%b inst=%h addr=%h err=%b want 1/%h/%h/0",
                             i - 1, out_valid0, inst0, addr0, err0, exp_w[i-1], 32'(4 * (i - 1)));
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_errors();
        do_reset();
        out_ready = 1'b1;
        set_addi(32'h800);
        next_cycle();
        set_in(1'b1, 32'h7F, 0, 0, 3, 4, 5, 32'h1234);
        @(negedge clk);
        checks++; if (inst0 !== 32'h8000_0093 || err0 !== 1'b1) begin errors++; $display("FAIL err_imm_range: inst=%h err=%b want 80000093/1", inst0, err0); end
        next_cycle();
        idle();
        @(negedge clk);
        checks++; if (inst0 !== 32'h0000_0013 || err0 !== 1'b1 || addr0 !== 32'd4) begin errors++; $display("FAIL err_bad_opcode: inst=%h err=%b addr=%h want 00000013/1/4", inst0, err0, addr0); end
        next_cycle();
    endtask

    task automatic test_backpressure();
        logic exp_rdy [4];
        logic [31:0] nxt;
        exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        out_ready = 1'b0;
        nxt = 1;
        for (int c = 0; c < 4; c++) begin
            set_addi(nxt);
            @(negedge clk);
            checks++; if (in_ready0 !== exp_rdy[c]) begin errors++; $display("FAIL bp_ready[%0d]: got %b want %b", c, in_ready0, exp_rdy[c]); end
            if (exp_rdy[c]) nxt = nxt + 1;
            next_cycle();
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (in_ready0 !== 1'b0 || addr0 !== 32'd0 || inst0 !== 32'h0010_0093) begin errors++; $display("FAIL bp_pop0: ready=%b addr=%h inst=%h want 0/0/00100093", in_ready0, addr0, inst0); end
        next_cycle();
        @(negedge clk);
        checks++; if (in_ready0 !== 1'b1 || addr0 !== 32'd4 || inst0 !== 32'h0020_0093) begin errors++; $display("FAIL bp_pop1: ready=%b addr=%h inst=%h want 1/4/00200093", in_ready0, addr0, inst0); end
        next_cycle();
        idle();
        @(negedge clk);
        checks++; if (out_valid0 !== 1'b1 || addr0 !== 32'd8 || inst0 !== 32'h0030_0093) begin errors++; $display("FAIL bp_pop2: valid=%b addr=%h inst=%h want 1/8/00300093", out_valid0, addr0, inst0); end
        next_cycle();
        @(negedge clk);
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL bp_empty: valid=%b want 0", out_valid0); end
        next_cycle();
    endtask

    task automatic test_wrap();
        logic [31:0] exp_a [3];
        exp_a = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) set_addi(32'(i)); else idle();
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (out_valid1 !== 1'b1 || addr1 !== exp_a[i-1]) begin
                    errors++;
                    $display("FAIL wrap_addr[%0d]: valid=%b addr=%h want 1/%h", i - 1, out_valid1, addr1, exp_a[i-1]);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        out_ready = 1'b0;
        set_addi(32'd7);
        next_cycle();
        next_cycle();
        idle();
        @(negedge clk);
        checks++; if (out_valid0 !== 1'b1 || in_ready0 !== 1'b0) begin errors++; $display("FAIL midrst_full: valid=%b ready=%b want 1/0", out_valid0, in_ready0); end
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid0 !== 1'b0 || inst0 !== 32'd0 || in_ready0 !== 1'b1) begin errors++; $display("FAIL midrst_async: valid=%b inst=%h ready=%b want 0/0/1", out_valid0, inst0, in_ready0); end
        next_cycle();
        rst = 1'b0;
        out_ready = 1'b1;
        set_addi(32'd9);
        next_cycle();
        idle();
        @(negedge clk);
        checks++; if (out_valid0 !== 1'b1 || addr0 !== 32'd0 || inst0 !== 32'h0090_0093) begin errors++; $display("FAIL midrst_restart: valid=%b addr=%h inst=%h want 1/0/00900093", out_valid0, addr0, inst0); end
        next_cycle();
    endtask

    task automatic test_random();
        logic [6:0]  ops [9];
        exp_t        q [$];
        logic [31:0] addr_m;
        logic [31:0] t_op, t_f3, t_f7, t_r1, t_r2, t_rd, t_im;
        logic [32:0] m;
        logic        v, do_push, do_pop;
        int          sel;
        ops = '{7'h33, 7'h67, 7'h03, 7'h13, 7'h23, 7'h63, 7'h17, 7'h37, 7'h6F};
        do_reset();
        addr_m = 32'd0;
        for (int c = 0; c < 800; c++) begin
            sel  = int'($urandom_range(0, 10));
            t_op = (sel < 9) ? 32'(ops[sel]) : ($urandom & 32'h7F);
            t_f3 = $urandom & 32'h7;
            t_f7 = $urandom & 32'h7F;
            t_r1 = $urandom & 32'h1F;
            t_r2 = $urandom & 32'h1F;
            t_rd = $urandom & 32'h1F;
            case ($urandom_range(0, 3))
                0: t_im = $urandom;
                1: t_im = 32'($urandom_range(0, 8191)) - 32'd4096;
                2: t_im = $urandom & 32'hFFFF_F000;
                default: t_im = 32'($urandom_range(0, 40));
            endcase
            v = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            set_in(v, t_op, t_f3, t_f7, t_r1, t_r2, t_rd, t_im);
            @(negedge clk);
            checks++; if (in_ready0 !== (q.size() < 2)) begin errors++; $display("FAIL rnd_ready c%0d: got %b want %b", c, in_ready0, q.size() < 2); end
            checks++; if (out_valid0 !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid c%0d: got %b want %b", c, out_valid0, q.size() > 0); end
            if (q.size() > 0) begin
                checks++;
                if (inst0 !== q[0].inst || addr0 !== q[0].addr || err0 !== q[0].err) begin
                    errors++;
                    $display("FAIL rnd_head c%0d: inst=%h addr=%h err=%b want %h/%h/%b",
                             c, inst0, addr0, err0, q[0].inst, q[0].addr, q[0].err);
                end
            end else begin
                checks++; if ({inst0, addr0, err0} !== 65'd0) begin errors++; $display("FAIL rnd_idle_zero c%0d: inst=%h addr=%h err=%b want zeros", c, inst0, addr0, err0); end
            end
            do_pop  = (q.size() > 0) && out_ready;
            do_push = v && (q.size() < 2);
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                m = model_encode(t_op, t_f3, t_f7, t_r1, t_r2, t_rd, t_im);
                q.push_back('{inst: m[31:0], addr: addr_m, err: m[32]});
                addr_m = addr_m + 32'd4;
            end
            next_cycle();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_errors();
        test_backpressure();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
